// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared constants for the data-memory responder: RV32
//               load/store funct3 codes, FSM state encoding, latency counter
//               width and a funct3 legality helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  // RV32 load/store funct3 codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Responder FSM encoding
  localparam int         ST_W = 2;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Width of the access-latency down-counter (LATENCY up to 15)
  localparam int LAT_CNT_W = 4;

  // Stores only know B/H/W; loads additionally have the unsigned forms.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!is_store) begin
      ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    end
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_if
// Description : Request/response channel between the load/store unit and the
//               data-memory responder. Both channels use valid/ready.
// Ports       : req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata
//               rsp_valid/rsp_ready/rsp_rdata/rsp_err
//               modport master = load/store unit, slave = responder
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : dmem_lane_align
// Description : Combinational byte-lane steering for RV32 loads and stores on
//               a little-endian 32-bit word.
// Ports       : funct3   in  3   access size / signedness
//               lane     in  2   byte address within the word
//               wdata    in  32  right-aligned store data
//               old_word in  32  current array word
//               wr_word  out 32  old_word with the selected lanes replaced
//               be       out 4   byte enables of the store
//               ld_data  out 32  sign/zero-extended load result
//               misalign out 1   half/word not naturally aligned
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane_align (
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] old_word,
  output logic [31:0] wr_word,
  output logic [3:0]  be,
  output logic [31:0] ld_data,
  output logic        misalign
);
  logic [31:0] w_rep;
  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_signed;

  assign w_shift  = old_word >> {lane, 3'b000};
  assign w_byte   = w_shift[7:0];
  assign w_half   = lane[1] ? old_word[31:16] : old_word[15:0];
  assign w_signed = ~funct3[2];

  always_comb begin
    be       = 4'b0000;
    w_rep    = wdata;
    misalign = 1'b0;
    ld_data  = 32'h0;
    case (funct3[1:0])
      2'b00: begin
        be      = 4'b0001 << lane;
        w_rep   = {4{wdata[7:0]}};
        ld_data = {{24{w_signed & w_byte[7]}}, w_byte};
      end
      2'b01: begin
        be       = lane[1] ? 4'b1100 : 4'b0011;
        w_rep    = {2{wdata[15:0]}};
        misalign = lane[0];
        ld_data  = {{16{w_signed & w_half[15]}}, w_half};
      end
      2'b10: begin
        be       = 4'b1111;
        misalign = |lane;
        ld_data  = old_word;
      end
      default: begin
        be = 4'b0000;
      end
    endcase
    // Replicated store data lets each enabled lane pick its own byte.
    for (int i = 0; i < 4; i++) begin
      wr_word[8*i +: 8] = be[i] ? w_rep[8*i +: 8] : old_word[8*i +: 8];
    end
  end
endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory responder with configurable access latency.
//               Accepts one load/store at a time, performs it on the edge that
//               enters RESP and holds the response until it is taken.
// Ports       : clk   in  1  rising-edge clock
//               Reset in  1  synchronous active-high reset
//               bus   slave modport of dmem_responder_if
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             Reset,
  dmem_responder_if.slave  bus
);
  localparam int                   AW       = $clog2(DEPTH);
  localparam logic [LAT_CNT_W-1:0] CNT_INIT = LAT_CNT_W'(LATENCY - 1);

  logic [ST_W-1:0]      r_state;
  logic [ST_W-1:0]      w_state_next;
  logic [LAT_CNT_W-1:0] r_cnt;
  logic                 r_we;
  logic [2:0]           r_funct3;
  logic [31:0]          r_addr;
  logic [31:0]          r_wdata;
  logic [31:0]          r_rdata;
  logic                 r_err;
  logic [31:0]          r_mem [DEPTH];

  logic        w_accept;
  logic        w_do_access;
  logic        w_acc_we;
  logic [2:0]  w_acc_f3;
  logic [31:0] w_acc_addr;
  logic [31:0] w_acc_wdata;
  logic [AW-1:0] w_idx;
  logic [31:0] w_old;
  logic [31:0] w_wr_word;
  logic [3:0]  w_be;
  logic [31:0] w_ld;
  logic        w_misalign;
  logic        w_oor;
  logic        w_err;
  logic        w_write;

  assign w_accept = bus.req_valid & bus.req_ready;

  // With LATENCY = 1 the access happens on the acceptance edge itself, so the
  // live request fields are used; otherwise the latched copy is.
  assign w_acc_we    = (r_state == IDLE) ? bus.req_we     : r_we;
  assign w_acc_f3    = (r_state == IDLE) ? bus.req_funct3 : r_funct3;
  assign w_acc_addr  = (r_state == IDLE) ? bus.req_addr   : r_addr;
  assign w_acc_wdata = (r_state == IDLE) ? bus.req_wdata  : r_wdata;

  assign w_do_access = ~Reset &
                       ((w_accept & (LATENCY == 1)) |
                        ((r_state == WAIT) & (r_cnt == LAT_CNT_W'(1))));

  assign w_idx = w_acc_addr[AW+1:2];
  assign w_old = r_mem[w_idx];
  assign w_oor = |(w_acc_addr >> (AW + 2));
  assign w_err = w_oor | w_misalign | ~f3_legal(w_acc_we, w_acc_f3);
  assign w_write = w_do_access & w_acc_we & ~w_err & (|w_be);

  dmem_lane_align u_align (
    .funct3   (w_acc_f3),
    .lane     (w_acc_addr[1:0]),
    .wdata    (w_acc_wdata),
    .old_word (w_old),
    .wr_word  (w_wr_word),
    .be       (w_be),
    .ld_data  (w_ld),
    .misalign (w_misalign)
  );

  // State register
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_next = (LATENCY == 1) ? RESP : WAIT;
      WAIT: if (r_cnt == LAT_CNT_W'(1)) w_state_next = RESP;
      RESP: if (bus.rsp_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Outputs; gated by Reset so nothing is offered during a reset cycle.
  always_comb begin
    bus.req_ready = (r_state == IDLE) & ~Reset;
    bus.rsp_valid = (r_state == RESP) & ~Reset;
    bus.rsp_rdata = r_rdata;
    bus.rsp_err   = r_err;
  end

  // Request latch, latency counter and response registers
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_cnt    <= '0;
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_rdata  <= 32'h0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we     <= bus.req_we;
        r_funct3 <= bus.req_funct3;
        r_addr   <= bus.req_addr;
        r_wdata  <= bus.req_wdata;
        r_cnt    <= CNT_INIT;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - LAT_CNT_W'(1);
      end
      if (w_do_access) begin
        r_rdata <= (w_acc_we | w_err) ? 32'h0 : w_ld;
        r_err   <= w_err;
      end
    end
  end

  // Data array; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[w_idx] <= w_wr_word;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Scoreboard bench for dmem_responder. Two instances: LATENCY=2
//               (main traffic) and LATENCY=4 (latency and mid-WAIT reset).
//               A byte-array model predicts every response.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;
  import dmem_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst     = 2'b11;
  logic [1:0]  d_valid = 2'b00;
  logic [1:0]  d_we    = 2'b00;
  logic [1:0]  d_rrdy  = 2'b00;
  logic [2:0]  d_f3    [2];
  logic [31:0] d_addr  [2];
  logic [31:0] d_wdata [2];
  logic [1:0]  m_rr, m_rv, m_err;
  logic [31:0] m_rd [2];

  dmem_responder_if ifa ();
  dmem_responder_if ifb ();

  assign ifa.req_valid = d_valid[0];  assign ifb.req_valid = d_valid[1];
  assign ifa.req_we = d_we[0];        assign ifb.req_we = d_we[1];
  assign ifa.req_funct3 = d_f3[0];    assign ifb.req_funct3 = d_f3[1];
  assign ifa.req_addr = d_addr[0];    assign ifb.req_addr = d_addr[1];
  assign ifa.req_wdata = d_wdata[0];  assign ifb.req_wdata = d_wdata[1];
  assign ifa.rsp_ready = d_rrdy[0];   assign ifb.rsp_ready = d_rrdy[1];
  assign m_rr  = {ifb.req_ready, ifa.req_ready};
  assign m_rv  = {ifb.rsp_valid, ifa.rsp_valid};
  assign m_err = {ifb.rsp_err, ifa.rsp_err};
  assign m_rd[0] = ifa.rsp_rdata;
  assign m_rd[1] = ifb.rsp_rdata;

  dmem_responder #(.DEPTH(1024), .LATENCY(2)) dut (
    .clk(clk), .Reset(rst[0]), .bus(ifa.slave));
  dmem_responder #(.DEPTH(1024), .LATENCY(4)) dut4 (
    .clk(clk), .Reset(rst[1]), .bus(ifb.slave));

  int   cyc = 0;
  int   n_vec = 0, n_err = 0;
  int   bp_mode [2];   // 0 random rsp_ready, 1 hold low, 2 hold high
  exp_t q0[$], q1[$];
  logic [7:0] mdl [2][4096];
  logic [1:0] prev_rv = 2'b00, prev_hs = 2'b00;
  logic [31:0] hold_rd [2];
  logic [1:0]  hold_err = 2'b00;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail(string name);
    n_vec++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? 2 : 4;
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  // Reference: byte-addressed little-endian memory, 4 KiB per instance.
  function automatic void model(input int k, input bit we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rd, output logic err);
    int sz;
    logic [31:0] v;
    bit legal;
    sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = we ? (f3 inside {F3_B, F3_H, F3_W})
               : (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    err = !legal || (addr >= 32'd4096) || ((addr % sz) != 0);
    rd = 32'h0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < sz; i++) mdl[k][int'(addr) + i] = wdata[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = mdl[k][int'(addr) + i];
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
        rd = v;
      end
    end
  endfunction

  // Monitor: checks latency, stability under backpressure and response data.
  function automatic void mon(input int k);
    exp_t e;
    if (m_rv[k]) begin
      if (prev_rv[k] && !prev_hs[k]) begin
        chk("hold_rdata", m_rd[k], hold_rd[k]);
        chk("hold_err", 32'(m_err[k]), 32'(hold_err[k]));
      end
      if (qsize(k) == 0) begin
        if (!prev_rv[k] || prev_hs[k]) fail("unexpected_rsp");
      end else begin
        e = (k == 0) ? q0[0] : q1[0];
        if (!prev_rv[k]) chk("latency", 32'(cyc - e.acc), 32'(lat(k)));
        if (d_rrdy[k]) begin
          if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
          chk("rdata", m_rd[k], e.rdata);
          chk("err", 32'(m_err[k]), 32'(e.err));
        end
      end
    end else if (prev_rv[k] && !prev_hs[k] && !rst[k]) begin
      fail("valid_dropped");
    end
    prev_rv[k]  = m_rv[k];
    prev_hs[k]  = m_rv[k] & d_rrdy[k];
    hold_rd[k]  = m_rd[k];
    hold_err[k] = m_err[k];
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) mon(k);
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++)
        d_rrdy[k] = (bp_mode[k] == 0) ? ($urandom_range(0, 3) != 0) : (bp_mode[k] == 2);
    end
  end

  task automatic issue(input int k, input bit we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata, input bit track);
    exp_t e;
    int n;
    @(posedge clk);
    #1;
    d_valid[k] = 1'b1; d_we[k] = we; d_f3[k] = f3; d_addr[k] = addr; d_wdata[k] = wdata;
    n = 0;
    @(negedge clk);
    while (!m_rr[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!m_rr[k]) begin
      fail("accept_timeout");
      d_valid[k] = 1'b0;
      return;
    end
    if (track) begin
      model(k, we, f3, addr, wdata, e.rdata, e.err);
      e.acc = cyc;
      if (k == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(posedge clk);
    #1;
    d_valid[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    int n;
    n = 0;
    while (qsize(k) > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (qsize(k) > 0) fail("drain_timeout");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] ld_f3 [5];
    logic [2:0] st_f3 [3];
    bit we;
    logic [2:0] f3;
    logic [31:0] addr;
    ld_f3 = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
    st_f3 = '{F3_B, F3_H, F3_W};
    bp_mode = '{2, 2};
    for (int k = 0; k < 2; k++) begin
      d_f3[k] = F3_W; d_addr[k] = 32'h0; d_wdata[k] = 32'h0;
    end

    // Reset with a request pending: nothing offered, nothing accepted.
    d_valid = 2'b11;
    d_we    = 2'b11;
    repeat (2) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk("rst_req_ready", 32'(m_rr[k]), 32'h0);
        chk("rst_rsp_valid", 32'(m_rv[k]), 32'h0);
      end
    end
    d_valid = 2'b00;
    rst     = 2'b00;
    #1;
    for (int k = 0; k < 2; k++) chk("post_rst_req_ready", 32'(m_rr[k]), 32'h1);

    bp_mode = '{0, 0};
    // Known contents for every word touched later.
    for (int a = 0; a < 256; a += 4) issue(0, 1'b1, F3_W, 32'(a), $urandom, 1'b1);
    issue(1, 1'b1, F3_W, 32'h40, 32'h0123_4567, 1'b1);

    // Directed sequence on the LATENCY=2 instance.
    issue(0, 1'b1, F3_W,   32'h10,   32'hDEAD_BEEF, 1'b1);
    issue(0, 1'b0, F3_W,   32'h10,   32'h0,         1'b1);
    issue(0, 1'b1, F3_W,   32'h10,   32'h0,         1'b1);
    issue(0, 1'b1, F3_B,   32'h13,   32'h80,        1'b1);
    issue(0, 1'b0, F3_W,   32'h10,   32'h0,         1'b1);
    issue(0, 1'b0, F3_B,   32'h13,   32'h0,         1'b1);
    issue(0, 1'b0, F3_BU,  32'h13,   32'h0,         1'b1);
    issue(0, 1'b1, F3_H,   32'h12,   32'h1234,      1'b1);
    issue(0, 1'b0, F3_HU,  32'h12,   32'h0,         1'b1);
    issue(0, 1'b0, F3_W,   32'h11,   32'h0,         1'b1);
    issue(0, 1'b1, F3_W,   32'h20,   32'hCAFE_F00D, 1'b1);
    issue(0, 1'b1, F3_H,   32'h21,   32'hFFFF,      1'b1);
    issue(0, 1'b0, F3_W,   32'h20,   32'h0,         1'b1);
    issue(0, 1'b0, F3_W,   32'h1000, 32'h0,         1'b1);
    issue(0, 1'b0, 3'b011, 32'h10,   32'h0,         1'b1);
    drain(0);

    // Backpressure: response must stay put while rsp_ready is low.
    bp_mode[0] = 1;
    issue(0, 1'b0, F3_W, 32'h10, 32'h0, 1'b1);
    for (int n = 0; n < 20 && !m_rv[0]; n++) @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(m_rv[0]), 32'h1);
      chk("bp_req_ready", 32'(m_rr[0]), 32'h0);
    end
    bp_mode[0] = 2;
    drain(0);
    @(negedge clk);
    chk("bp_release_req_ready", 32'(m_rr[0]), 32'h1);
    chk("bp_release_rsp_valid", 32'(m_rv[0]), 32'h0);
    bp_mode[0] = 0;

    // Reset in the second WAIT cycle of a store: store must be discarded.
    drain(1);
    issue(1, 1'b1, F3_W, 32'h40, 32'h5555_AAAA, 1'b0);
    @(posedge clk);
    #1;
    rst[1] = 1'b1;
    @(posedge clk);
    #1;
    rst[1] = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("mid_rst_no_rsp", 32'(m_rv[1]), 32'h0);
    end
    issue(1, 1'b0, F3_W, 32'h40, 32'h0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) < 13)
        f3 = we ? st_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 4)];
      else
        f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) addr = 32'h1000 + ($urandom & 32'hFFFF);
      else addr = 32'($urandom_range(0, 255));
      issue(0, we, f3, addr, $urandom, 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    for (int i = 0; i < 20; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = we ? st_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 4)];
      issue(1, we, f3, 32'h40 + 32'($urandom_range(0, 3)), $urandom, 1'b1);
    end
    drain(0);
    drain(1);
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
